// File: rtl/alu_add_scheduler_pkg.sv
// Shared types and helpers for the ALU add scheduler.
//   sched_state_e : arbitration FSM states (idle = 1'b0, busy = 1'b1)
//   id_width()    : requester-index width, never narrower than one bit
package alu_add_scheduler_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } sched_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/AddrCarryLookAhead.sv
// WIDTH-bit carry-lookahead adder, purely combinational.
//   iwv_a, iwv_b : operands
//   iw_cin       : carry in
//   owv_output   : {carry_out, sum}
module AddrCarryLookAhead #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] iwv_a,
  input  logic [WIDTH-1:0] iwv_b,
  input  logic             iw_cin,
  output logic [WIDTH:0]   owv_output
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic             term;

  assign gen  = iwv_a & iwv_b;
  assign prop = iwv_a ^ iwv_b;

  // Each carry is the flattened sum of products: a generate at bit j that
  // propagates through bits j+1..i, or the carry-in propagating through 0..i.
  always_comb begin
    carry    = '0;
    term     = 1'b0;
    carry[0] = iw_cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      term = iw_cin;
      for (int unsigned j = 0; j <= i; j++) term = term & prop[j];
      carry[i+1] = term;
      for (int unsigned j = 0; j <= i; j++) begin
        term = gen[j];
        for (int unsigned m = j + 1; m <= i; m++) term = term & prop[m];
        carry[i+1] = carry[i+1] | term;
      end
    end
  end

  assign owv_output = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i       : request vector
//   ptr_i       : highest-priority index (must be < NREQ)
//   grant_oh_o  : one-hot grant
//   grant_idx_o : grant index
//   any_req_o   : at least one request present
module alu_rr_arbiter
  import alu_add_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  localparam int unsigned IdW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_oh_o,
  output logic [IdW-1:0]  grant_idx_o,
  output logic            any_req_o
);

  logic [IdW-1:0] idx;

  // Scan from the pointer upward, wrapping; the first hit wins.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_req_o   = 1'b0;
    idx         = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IdW'((32'(ptr_i) + i) % NREQ);
      if (!any_req_o && req_i[idx]) begin
        any_req_o       = 1'b1;
        grant_oh_o[idx] = 1'b1;
        grant_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/alu_add_scheduler.sv
// Shares one carry-lookahead adder between NREQ requesters. Each grant is
// held for a whole multi-word add (LS word first) with the carry chained
// between beats; every accepted beat lands in a single result register.
// Optional feature macro: ALU_ADD_SCHED_SUB_EN (subtract via iwv_req_sub).
//   iw_clk / iw_rst_n           : clock, async active-low reset
//   iwv_req_valid/owv_req_ready : per-requester beat handshake
//   iwv_req_x/y                 : packed operand words, requester k at [k*WIDTH +: WIDTH]
//   iwv_req_last/iwv_req_sub    : final-word flag / subtract (first beat)
//   ow_res_valid/iw_res_ready   : result handshake
//   owv_res_sum, ow_res_carry, ow_res_last, owv_res_id, owv_res_beat : result fields
module alu_add_scheduler
  import alu_add_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NREQ   = 3,
  parameter int unsigned BEAT_W = 4,
  localparam int unsigned IdW = id_width(NREQ)
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst_n,
  input  logic [NREQ-1:0]       iwv_req_valid,
  output logic [NREQ-1:0]       owv_req_ready,
  input  logic [NREQ*WIDTH-1:0] iwv_req_x,
  input  logic [NREQ*WIDTH-1:0] iwv_req_y,
  input  logic [NREQ-1:0]       iwv_req_last,
  input  logic [NREQ-1:0]       iwv_req_sub,
  output logic                  ow_res_valid,
  input  logic                  iw_res_ready,
  output logic [WIDTH-1:0]      owv_res_sum,
  output logic                  ow_res_carry,
  output logic                  ow_res_last,
  output logic [IdW-1:0]        owv_res_id,
  output logic [BEAT_W-1:0]     owv_res_beat
);

  sched_state_e state_q, state_d;
  logic [IdW-1:0]    grant_q, grant_d, rr_q, rr_d, rr_next;
  logic [NREQ-1:0]   grant_oh_q, grant_oh_d;
  logic              carry_q, carry_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic              res_valid_q, res_valid_d, res_carry_q, res_carry_d, res_last_q, res_last_d;
  logic [WIDTH-1:0]  res_sum_q, res_sum_d;
  logic [IdW-1:0]    res_id_q, res_id_d;
  logic [BEAT_W-1:0] res_beat_q, res_beat_d;

  logic [NREQ-1:0]  arb_oh;
  logic [IdW-1:0]   arb_idx;
  logic             arb_any;
  logic             sel_valid, sel_last;
  logic [WIDTH-1:0] sel_x, sel_y, add_b;
  logic             add_cin, sub_eff;
  logic [WIDTH:0]   add_out;
  logic             busy, res_free, accept, first_beat;

  alu_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req_i       (iwv_req_valid),
    .ptr_i       (rr_q),
    .grant_oh_o  (arb_oh),
    .grant_idx_o (arb_idx),
    .any_req_o   (arb_any)
  );

  // Operand mux for the locked grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_q == IdW'(k)) begin
        sel_valid = iwv_req_valid[k];
        sel_last  = iwv_req_last[k];
        sel_x     = iwv_req_x[k*WIDTH +: WIDTH];
        sel_y     = iwv_req_y[k*WIDTH +: WIDTH];
      end
    end
  end

  assign busy          = (state_q == StBusy);
  assign res_free      = !res_valid_q || iw_res_ready;
  assign accept        = busy && sel_valid && res_free;
  assign owv_req_ready = (busy && res_free) ? grant_oh_q : '0;
  // Beat counter only returns to zero at transaction end, so zero marks the first beat.
  assign first_beat    = (beat_q == '0);

`ifdef ALU_ADD_SCHED_SUB_EN
  logic sel_sub, sub_q, sub_d;

  always_comb begin
    sel_sub = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_q == IdW'(k)) sel_sub = iwv_req_sub[k];
    end
  end

  // The first beat uses the live request bit; later beats use the latched copy.
  assign sub_eff = first_beat ? sel_sub : sub_q;
  assign sub_d   = (accept && first_beat) ? sel_sub : sub_q;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) sub_q <= 1'b0;
    else           sub_q <= sub_d;
  end
`else
  logic unused_sub;
  assign unused_sub = ^iwv_req_sub;
  assign sub_eff    = 1'b0;
`endif

  assign add_b   = sub_eff ? ~sel_y : sel_y;
  assign add_cin = first_beat ? sub_eff : carry_q;

  AddrCarryLookAhead #(
    .WIDTH(WIDTH)
  ) u_adder (
    .iwv_a      (sel_x),
    .iwv_b      (add_b),
    .iw_cin     (add_cin),
    .owv_output (add_out)
  );

  always_comb begin
    rr_next = grant_q + 1'b1;
    if (32'(grant_q) >= NREQ - 1) rr_next = '0;
  end

  // Arbitration / transaction FSM.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    rr_d       = rr_q;
    carry_d    = carry_q;
    beat_d     = beat_q;
    case (state_q)
      StIdle: begin
        if (arb_any) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_oh;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (accept) begin
          if (sel_last) begin
            state_d = StIdle;
            rr_d    = rr_next;
            carry_d = 1'b0;
            beat_d  = '0;
          end else begin
            carry_d = add_out[WIDTH];
            beat_d  = (beat_q == {BEAT_W{1'b1}}) ? beat_q : beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result register: loads on accept, otherwise empties on drain.
  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_carry_d = res_carry_q;
    res_last_d  = res_last_q;
    res_id_d    = res_id_q;
    res_beat_d  = res_beat_q;
    if (accept) begin
      res_valid_d = 1'b1;
      res_sum_d   = add_out[WIDTH-1:0];
      res_carry_d = add_out[WIDTH];
      res_last_d  = sel_last;
      res_id_d    = grant_q;
      res_beat_d  = beat_q;
    end else if (iw_res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      rr_q        <= '0;
      carry_q     <= 1'b0;
      beat_q      <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_id_q    <= '0;
      res_beat_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      rr_q        <= rr_d;
      carry_q     <= carry_d;
      beat_q      <= beat_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_carry_q <= res_carry_d;
      res_last_q  <= res_last_d;
      res_id_q    <= res_id_d;
      res_beat_q  <= res_beat_d;
    end
  end

  assign ow_res_valid = res_valid_q;
  assign owv_res_sum  = res_sum_q;
  assign ow_res_carry = res_carry_q;
  assign ow_res_last  = res_last_q;
  assign owv_res_id   = res_id_q;
  assign owv_res_beat = res_beat_q;

endmodule

// File: tb/tb_alu_add_scheduler.sv
// Bench for alu_add_scheduler (WIDTH=8, NREQ=3, BEAT_W=4). Expected beats come
// from whole-number arithmetic on the full multi-word operands, kept per requester.
module tb_alu_add_scheduler;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int BW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_last, req_sub;
  logic [N*W-1:0]  req_x, req_y;
  logic            res_valid, res_ready, res_carry, res_last;
  logic [W-1:0]    res_sum;
  logic [1:0]      res_id;
  logic [BW-1:0]   res_beat;

  always #5 clk = ~clk;

  alu_add_scheduler #(
    .WIDTH  (W),
    .NREQ   (N),
    .BEAT_W (BW)
  ) dut (
    .iw_clk        (clk),
    .iw_rst_n      (rst_n),
    .iwv_req_valid (req_valid),
    .owv_req_ready (req_ready),
    .iwv_req_x     (req_x),
    .iwv_req_y     (req_y),
    .iwv_req_last  (req_last),
    .iwv_req_sub   (req_sub),
    .ow_res_valid  (res_valid),
    .iw_res_ready  (res_ready),
    .owv_res_sum   (res_sum),
    .ow_res_carry  (res_carry),
    .ow_res_last   (res_last),
    .owv_res_id    (res_id),
    .owv_res_beat  (res_beat)
  );

  typedef struct packed {
    logic [W-1:0]  sum;
    logic          carry;
    logic          last;
    logic [BW-1:0] beat;
  } exp_t;

  exp_t exp_q[N][$];
  int   id_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by a test

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [263:0] rand_wide();
    logic [287:0] v;
    for (int j = 0; j < 9; j++) v[32*j +: 32] = $urandom;
    return v[263:0];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < N; k++) exp_q[k].delete();
    id_log.delete();
  endtask

  // Caller must be at posedge+1. Returns at posedge+1 after the last beat is accepted.
  task automatic send_txn(input int k, input int nb, input logic [263:0] xv,
                          input logic [263:0] yv, input bit sub, input int gap_max,
                          output int wait0);
    logic [263:0] fmask, mask, yeff, t;
    bit   se;
    exp_t e;
    int   waits;
    bit   timed_out;
    se = 1'b0;
`ifdef ALU_ADD_SCHED_SUB_EN
    se = sub;
`endif
    fmask = (264'(1) << (W * nb)) - 264'(1);
    yeff  = se ? (~yv & fmask) : yv;
    for (int i = 0; i < nb; i++) begin
      mask    = (264'(1) << (W * (i + 1))) - 264'(1);
      t       = (xv & mask) + (yeff & mask) + 264'(se);
      e.sum   = t[W*i +: W];
      e.carry = t[W*(i+1)];
      e.last  = (i == nb - 1);
      e.beat  = (i < 15) ? 4'(i) : 4'd15;
      exp_q[k].push_back(e);
    end
    wait0     = 0;
    timed_out = 1'b0;
    for (int i = 0; i < nb && !timed_out; i++) begin
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (gap > 0) begin
        req_valid[k] = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      req_valid[k]        = 1'b1;
      req_x[k*W +: W]     = xv[W*i +: W];
      req_y[k*W +: W]     = yv[W*i +: W];
      req_last[k]         = (i == nb - 1);
      req_sub[k]          = sub;
      waits = 0;
      forever begin
        @(negedge clk);
        if (req_ready[k]) break;
        waits++;
        if (waits > 600) begin
          check_eq("accept_timeout", 64'(k), 64'hFF);
          timed_out = 1'b1;
          break;
        end
      end
      if (i == 0) wait0 = waits;
      @(posedge clk);
      #1;
    end
    req_valid[k] = 1'b0;
  endtask

  task automatic monitor_loop();
    int   id;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && res_valid) begin
        id = int'(res_id);
        if (id >= N || exp_q[id].size() == 0) begin
          check_eq("spurious_beat", 64'(id), 64'hFF);
        end else begin
          e = exp_q[id][0];
          check_eq("sum", 64'(res_sum), 64'(e.sum));
          check_eq("carry", 64'(res_carry), 64'(e.carry));
          check_eq("last", 64'(res_last), 64'(e.last));
          check_eq("beat", 64'(res_beat), 64'(e.beat));
          if (res_ready) begin
            void'(exp_q[id].pop_front());
            if (e.last) id_log.push_back(id);
          end else begin
            check_eq("req_ready_while_stalled", 64'(req_ready), 64'(0));
          end
        end
      end
    end
  endtask

  task automatic ready_loop();
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      res_ready = 1'b1;
      else if (rdy_mode == 1) res_ready = ($urandom_range(9, 0) < 7);
    end
  endtask

  task automatic wait_drain(input int limit);
    int c;
    c = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && c < limit) begin
      @(posedge clk);
      c++;
    end
    check_eq("drain_pending", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    check_eq({tag, "_res_sum"}, 64'(res_sum), 64'(0));
    check_eq({tag, "_res_carry"}, 64'(res_carry), 64'(0));
    check_eq({tag, "_res_last"}, 64'(res_last), 64'(0));
    check_eq({tag, "_res_id"}, 64'(res_id), 64'(0));
    check_eq({tag, "_res_beat"}, 64'(res_beat), 64'(0));
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'(0));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_stream(input int k);
    int w;
    repeat (8) begin
      send_txn(k, int'($urandom_range(4, 1)), rand_wide(), rand_wide(),
               bit'($urandom_range(1, 0)), 2, w);
      repeat ($urandom_range(3, 0)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, c;
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_sub   = '0;
    req_x     = '0;
    req_y     = '0;
    res_ready = 1'b1;
    fork
      monitor_loop();
      ready_loop();
    join_none
    do_reset();
    mon_en = 1'b1;

    // Single beat: 0x7F + 0x01, one arbitration cycle, result two cycles after valid.
    send_txn(0, 1, 264'h7F, 264'h01, 1'b0, 0, w);
    check_eq("first_beat_wait", 64'(w), 64'(1));
    @(negedge clk);
    check_eq("res_valid_latency", 64'(res_valid), 64'(1));
    @(posedge clk);
    #1;

    // Two beats with carry chain: 0x00FF + 0x0001.
    send_txn(1, 2, 264'h00FF, 264'h0001, 1'b0, 0, w);
    wait_drain(50);

    // Subtract (honoured only with the feature enabled; otherwise plain add).
    send_txn(0, 1, 264'h05, 264'h07, 1'b1, 0, w);
    send_txn(0, 1, 264'h07, 264'h05, 1'b1, 0, w);
    wait_drain(50);

    // Round-robin order after reset with all three requesting.
    do_reset();
    fork
      begin
        send_txn(0, 1, 264'h11, 264'h22, 1'b0, 0, w);
        send_txn(0, 1, 264'h33, 264'h44, 1'b0, 0, w);
      end
      send_txn(1, 1, 264'h55, 264'h66, 1'b0, 0, w);
      send_txn(2, 1, 264'h77, 264'h88, 1'b0, 0, w);
    join
    wait_drain(50);
    check_eq("rr_order_0", 64'(id_log.size() > 0 ? id_log[0] : 99), 64'(0));
    check_eq("rr_order_1", 64'(id_log.size() > 1 ? id_log[1] : 99), 64'(1));
    check_eq("rr_order_2", 64'(id_log.size() > 2 ? id_log[2] : 99), 64'(2));
    check_eq("rr_order_3", 64'(id_log.size() > 3 ? id_log[3] : 99), 64'(0));

    // Downstream stall of 5 cycles in the middle of a 4-beat transaction.
    rdy_mode  = 2;
    res_ready = 1'b1;
    fork
      send_txn(2, 4, rand_wide(), rand_wide(), 1'b0, 0, w);
      begin
        c = 0;
        while (c < 100 && !(res_valid && res_beat == 4'd1 && res_id == 2'd2)) begin
          @(negedge clk);
          c++;
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    join
    rdy_mode = 0;
    wait_drain(50);

    // Beat counter saturation on a 17-word transaction.
    send_txn(0, 17, rand_wide(), rand_wide(), 1'b0, 0, w);
    wait_drain(100);

    // Reset during beat 1 of a 3-beat transaction; pointer must return to 0.
    send_txn(0, 1, 264'h01, 264'h02, 1'b0, 0, w);
    wait_drain(50);
    mon_en          = 1'b0;
    req_valid[1]    = 1'b1;
    req_x[1*W +: W] = 8'h11;
    req_y[1*W +: W] = 8'h22;
    req_last[1]     = 1'b0;
    c = 0;
    forever begin
      @(negedge clk);
      if (req_ready[1] || c > 50) break;
      c++;
    end
    check_eq("abort_grant_wait", 64'(c <= 50), 64'(1));
    @(posedge clk);
    #1;
    req_x[1*W +: W] = 8'h33;
    req_y[1*W +: W] = 8'h44;
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    req_valid = '0;
    clear_model();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    fork
      send_txn(0, 1, 264'hA0, 264'h0A, 1'b0, 0, w);
      send_txn(1, 1, 264'hB0, 264'h0B, 1'b0, 0, w);
      send_txn(2, 1, 264'hC0, 264'h0C, 1'b0, 0, w);
    join
    wait_drain(50);
    check_eq("grant_after_reset", 64'(id_log.size() > 0 ? id_log[0] : 99), 64'(0));

    // Random traffic from all requesters with random downstream backpressure.
    rdy_mode = 1;
    fork
      rand_stream(0);
      rand_stream(1);
      rand_stream(2);
    join
    rdy_mode = 0;
    wait_drain(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
